// File: rtl/cordic_seq_rotate_if.sv
`default_nettype none
// ============================================================================
// Module      : cordic_seq_rotate_if
// Description : Sample/result bundle for the iterative CORDIC rotator.
//               Signal names are from the rotator's point of view.
//                 i_valid  - sample valid (accepted only while o_ready=1)
//                 i_xval   - signed x input, IW bits
//                 i_yval   - signed y input, IW bits
//                 i_phase  - unsigned CCW rotation angle, PW bits = 1 turn
//                 o_ready  - rotator idle, can accept a sample
//                 o_valid  - one-cycle result strobe
//                 o_xval   - signed rotated x, WW bits, gain-scaled
//                 o_yval   - signed rotated y, WW bits, gain-scaled
//               master : sample source / result sink
//               slave  : the rotator
// Revision    : 1.0 - initial release
// ============================================================================
interface cordic_seq_rotate_if #(
   parameter int IW = 12,
   parameter int WW = 15,
   parameter int PW = 16
);
   logic                 i_valid;
   logic signed [IW-1:0] i_xval;
   logic signed [IW-1:0] i_yval;
   logic        [PW-1:0] i_phase;
   logic                 o_ready;
   logic                 o_valid;
   logic signed [WW-1:0] o_xval;
   logic signed [WW-1:0] o_yval;

   modport master (
      output i_valid, i_xval, i_yval, i_phase,
      input  o_ready, o_valid, o_xval, o_yval
   );

   modport slave (
      input  i_valid, i_xval, i_yval, i_phase,
      output o_ready, o_valid, o_xval, o_yval
   );
endinterface
`default_nettype wire

// File: rtl/cordic_seq_rotate.sv
`default_nettype none
// ============================================================================
// Module      : cordic_seq_rotate
// Description : Iterative CORDIC rotator, one micro-rotation per clock.
//               Rotates (x, y) counter-clockwise by i_phase and returns
//               unrounded WW-bit results carrying the CORDIC gain, ready to
//               feed a WW->OW rounding stage (o_valid is its clock enable).
// Ports       : i_clk   - clock
//               i_reset - synchronous, active-high reset
//               bus     - cordic_seq_rotate_if.slave (sample in, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module cordic_seq_rotate #(
   parameter int IW      = 12,
   parameter int WW      = 15,
   parameter int PW      = 16,
   parameter int NSTAGES = 12
) (
   input  wire logic          i_clk,
   input  wire logic          i_reset,
   cordic_seq_rotate_if.slave bus
);

   localparam int CW  = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;
   localparam int FW  = WW - IW - 1;   // guard bits appended below the LSB
   localparam int RSH = 32 - PW;       // 32-bit angle table down to PW bits

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ROTATE = 2'd1,
      S_OUT    = 2'd2
   } state_t;

   // atan(2^-i) as a fraction of a full turn, scaled by 2^32. Beyond i=15
   // atan(x) ~= x, so the entry is simply 2^32/(2*pi) shifted down by i.
   function automatic logic [31:0] atan32(input int i);
      case (i)
         0:       atan32 = 32'h2000_0000;
         1:       atan32 = 32'h12E4_051D;
         2:       atan32 = 32'h09FB_385B;
         3:       atan32 = 32'h0511_11D4;
         4:       atan32 = 32'h028B_0D43;
         5:       atan32 = 32'h0145_D7E1;
         6:       atan32 = 32'h00A2_F61E;
         7:       atan32 = 32'h0051_7C55;
         8:       atan32 = 32'h0028_BE53;
         9:       atan32 = 32'h0014_5F2E;
         10:      atan32 = 32'h000A_2F98;
         11:      atan32 = 32'h0005_17CC;
         12:      atan32 = 32'h0002_8BE6;
         13:      atan32 = 32'h0001_45F3;
         14:      atan32 = 32'h0000_A2F9;
         15:      atan32 = 32'h0000_517C;
         default: atan32 = 32'h28BE_60DB >> i;
      endcase
   endfunction

   // Round-to-nearest reduction of the 32-bit entry to PW bits.
   function automatic logic [PW-1:0] atan_pw(input int i);
      logic [32:0] t;
      t = {1'b0, atan32(i)} + ((33'd1 << RSH) >> 1);
      atan_pw = t[RSH +: PW];
   endfunction

   state_t               r_state;
   logic [CW-1:0]        r_count;
   logic signed [WW-1:0] r_x;
   logic signed [WW-1:0] r_y;
   logic [PW-1:0]        r_z;
   logic                 r_ready;
   logic                 r_valid;
   logic signed [WW-1:0] r_xout;
   logic signed [WW-1:0] r_yout;

   logic signed [WW-1:0] w_ex;
   logic signed [WW-1:0] w_ey;
   logic signed [WW-1:0] w_xsh;
   logic signed [WW-1:0] w_ysh;
   logic signed [WW-1:0] w_xn;
   logic signed [WW-1:0] w_yn;
   logic [PW-1:0]        w_zn;
   logic [PW-1:0]        w_atan;

   // Sign bit duplicated for one bit of growth headroom, zeros as guard bits.
   assign w_ex = {bus.i_xval[IW-1], bus.i_xval, {FW{1'b0}}};
   assign w_ey = {bus.i_yval[IW-1], bus.i_yval, {FW{1'b0}}};

   assign w_xsh = r_x >>> r_count;
   assign w_ysh = r_y >>> r_count;

   // One micro-rotation; the sign of the residual angle picks the direction.
   always_comb begin
      w_atan = atan_pw(int'(r_count));
      if (!r_z[PW-1]) begin
         w_xn = r_x - w_ysh;
         w_yn = r_y + w_xsh;
         w_zn = r_z - w_atan;
      end else begin
         w_xn = r_x + w_ysh;
         w_yn = r_y - w_xsh;
         w_zn = r_z + w_atan;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_z     <= '0;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_xout  <= '0;
         r_yout  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.i_valid) begin
                  // Quadrant pre-rotation by a multiple of 90 degrees leaves
                  // a residual angle in [0, quarter turn) for the iterations.
                  case (bus.i_phase[PW-1 -: 2])
                     2'b00: begin r_x <= w_ex;  r_y <= w_ey;  end
                     2'b01: begin r_x <= -w_ey; r_y <= w_ex;  end
                     2'b10: begin r_x <= -w_ex; r_y <= -w_ey; end
                     default: begin r_x <= w_ey; r_y <= -w_ex; end
                  endcase
                  r_z     <= {2'b00, bus.i_phase[PW-3:0]};
                  r_count <= '0;
                  r_ready <= 1'b0;
                  r_state <= S_ROTATE;
               end
            end
            S_ROTATE: begin
               r_x <= w_xn;
               r_y <= w_yn;
               r_z <= w_zn;
               if (r_count == CW'(NSTAGES - 1)) begin
                  r_xout  <= w_xn;
                  r_yout  <= w_yn;
                  r_valid <= 1'b1;
                  r_state <= S_OUT;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            S_OUT: begin
               r_valid <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
            default: begin
               r_valid <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.o_ready = r_ready;
   assign bus.o_valid = r_valid;
   assign bus.o_xval  = r_xout;
   assign bus.o_yval  = r_yout;

endmodule
`default_nettype wire

// File: tb/tb_cordic_seq_rotate.sv
`default_nettype none
// ============================================================================
// Module      : tb_cordic_seq_rotate
// Description : Self-checking bench for cordic_seq_rotate. Accepted samples
//               push a floating-point expected rotation onto a scoreboard;
//               an independent monitor pops and compares on every o_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cordic_seq_rotate;

   localparam int IW      = 12;
   localparam int WW      = 15;
   localparam int PW      = 16;
   localparam int NSTAGES = 12;

   localparam real DIR_TOL = 8.0;
   localparam real FS_TOL  = 16.0;
   // Random vectors reach full scale, where residual angle error and
   // truncation of the shifted terms can add up past the directed allowance.
   localparam real RND_TOL = 12.0;
   localparam int  WAIT_MAX = 200;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   cordic_seq_rotate_if #(.IW(IW), .WW(WW), .PW(PW)) bus ();

   cordic_seq_rotate #(
      .IW(IW), .WW(WW), .PW(PW), .NSTAGES(NSTAGES)
   ) dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   typedef struct {
      real ex;
      real ey;
      real tol;
      int  acc;
      bit  magchk;
      real mag;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   real  gain;
   bit   hold_en   = 1'b0;
   bit   have_held = 1'b0;
   int   held_x, held_y;

   always @(posedge clk) cyc <= cyc + 1;

   // Ideal rotation scaled by the CORDIC gain and the guard-bit shift.
   function automatic void model(input int x, input int y, input int ph,
                                 output real ex, output real ey);
      real th;
      th = 2.0 * 3.14159265358979 * real'(ph) / real'(1 << PW);
      ex = gain * (real'(x) * $cos(th) - real'(y) * $sin(th));
      ey = gain * (real'(x) * $sin(th) + real'(y) * $cos(th));
   endfunction

   task automatic check_near(input string name, input real act,
                             input real exp, input real tol);
      real d;
      checks++;
      d = act - exp;
      if (d < 0.0) d = -d;
      if (d > tol) begin
         errors++;
         $display("FAIL %s actual %0.1f required %0.1f +/- %0.0f",
                  name, act, exp, tol);
      end
   endtask

   task automatic check_eq(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.o_valid) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL stray_valid actual o_valid=1 required no strobe");
         end else begin
            mon_e = sb.pop_front();
            check_near("x", real'(bus.o_xval), mon_e.ex, mon_e.tol);
            check_near("y", real'(bus.o_yval), mon_e.ey, mon_e.tol);
            // Strobe appears in the cycle after edge accept+NSTAGES.
            check_eq("latency", cyc - mon_e.acc, NSTAGES);
            if (mon_e.magchk)
               check_near("magnitude",
                          $sqrt(real'(bus.o_xval) * real'(bus.o_xval) +
                                real'(bus.o_yval) * real'(bus.o_yval)),
                          mon_e.mag, FS_TOL);
         end
         held_x    = int'(bus.o_xval);
         held_y    = int'(bus.o_yval);
         have_held = 1'b1;
      end else if (!rst && hold_en && have_held) begin
         check_eq("hold_x", int'(bus.o_xval), held_x);
         check_eq("hold_y", int'(bus.o_yval), held_y);
      end
   end

   task automatic push_exp(input int x, input int y, input int ph,
                           input real tol, input bit magchk);
      exp_t e;
      model(x, y, ph, e.ex, e.ey);
      e.tol    = tol;
      e.acc    = cyc + 1;
      e.magchk = magchk;
      e.mag    = $sqrt(e.ex * e.ex + e.ey * e.ey);
      sb.push_back(e);
   endtask

   // Waits for o_ready, presents one sample for one edge, then scrambles
   // the inputs so a design that samples late would be caught.
   task automatic send(input int x, input int y, input int ph,
                       input real tol, input bit magchk);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.o_ready && n < WAIT_MAX) begin
         @(negedge clk);
         n++;
      end
      if (!bus.o_ready) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout actual o_ready=0 required 1");
      end else begin
         bus.i_valid = 1'b1;
         bus.i_xval  = IW'(x);
         bus.i_yval  = IW'(y);
         bus.i_phase = PW'(ph);
         push_exp(x, y, ph, tol, magchk);
         @(negedge clk);
         bus.i_valid = 1'b0;
         bus.i_xval  = IW'($urandom);
         bus.i_yval  = IW'($urandom);
         bus.i_phase = PW'($urandom);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < WAIT_MAX * 4) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual %0d pending required 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog actual timeout required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int x, y, ph, dirs[6];

      gain = real'(1 << (WW - IW - 1));
      for (int i = 0; i < NSTAGES; i++)
         gain = gain * $sqrt(1.0 + $pow(2.0, -2.0 * i));

      bus.i_valid = 1'b0;
      bus.i_xval  = '0;
      bus.i_yval  = '0;
      bus.i_phase = '0;

      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("reset_ready", int'(bus.o_ready), 1);
      check_eq("reset_valid", int'(bus.o_valid), 0);
      check_eq("reset_x", int'(bus.o_xval), 0);
      check_eq("reset_y", int'(bus.o_yval), 0);

      // Axis and diagonal rotations of (1000, 0)
      dirs = '{'h0000, 'h4000, 'h8000, 'hC000, 'h2000, 'hE000};
      foreach (dirs[k]) begin
         send(1000, 0, dirs[k], DIR_TOL, 1'b0);
         drain();
      end

      // Full-scale input, 135 degrees
      send(-2048, 0, 'h6000, FS_TOL, 1'b1);
      drain();

      // Random sweep inside the allowed magnitude circle, back to back
      for (int n = 0; n < 1000; n++) begin
         do begin
            x = int'($urandom_range(4096, 0)) - 2048;
            y = int'($urandom_range(4096, 0)) - 2048;
         end while (x * x + y * y > 2048 * 2048 || x > 2047 || y > 2047);
         ph = int'($urandom_range(65535, 0));
         send(x, y, ph, RND_TOL, 1'b0);
      end
      drain();

      // i_valid every cycle with fresh data; only samples offered while
      // o_ready=1 are accepted, and outputs must hold between strobes.
      hold_en = 1'b1;
      for (int n = 0; n < 90; n++) begin
         @(negedge clk);
         x  = int'($urandom_range(2000, 0)) - 1000;
         y  = int'($urandom_range(2000, 0)) - 1000;
         ph = int'($urandom_range(65535, 0));
         bus.i_valid = 1'b1;
         bus.i_xval  = IW'(x);
         bus.i_yval  = IW'(y);
         bus.i_phase = PW'(ph);
         if (bus.o_ready) push_exp(x, y, ph, RND_TOL, 1'b0);
      end
      @(negedge clk);
      bus.i_valid = 1'b0;
      drain();
      hold_en = 1'b0;

      // Reset in the middle of a rotation discards it
      send(1000, 0, 'h2000, DIR_TOL, 1'b0);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      check_eq("abort_ready", int'(bus.o_ready), 1);
      check_eq("abort_valid", int'(bus.o_valid), 0);
      check_eq("abort_x", int'(bus.o_xval), 0);
      check_eq("abort_y", int'(bus.o_yval), 0);
      repeat (2 * NSTAGES) @(negedge clk);

      // Fresh sample after the abort
      send(700, -300, 'h5555, DIR_TOL, 1'b0);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
